serial_operand_loader: RTL and testbench
========================================

# serial_operand_loader

Upstream feeder for the bit-serial adder datapath. It accepts a parallel operand pair (a, b, cin) through a valid/ready handshake and emits the pair LSB-first, one bit per accepted beat. Each beat carries first/last framing so the downstream full-adder/carry-flop stage can seed its carry with cin on bit 0 and close the word on bit N-1. Back-to-back words stream with no idle cycle.

## Interface
- N, default 16, operand width in bits; legal range N ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  parallel operand pair present.
- in_ready  output  1  loader can accept a pair this cycle.
- in_a  input  N  operand A.
- in_b  input  N  operand B.
- in_cin  input  1  carry-in for this word.
- ser_valid  output  1  a serial beat is presented.
- ser_ready  input  1  downstream consumes the beat this cycle (stall when low).
- ser_a  output  1  current bit of A.
- ser_b  output  1  current bit of B.
- ser_cin  output  1  in_cin on the first beat; 0 on all other beats.
- ser_first  output  1  beat is bit 0 of the word.
- ser_last  output  1  beat is bit N-1 of the word.
- busy  output  1  a word is loaded and not fully sent.

## Operation
- FSM states: IDLE, SHIFT. The state register resets to IDLE.
- Load: when in_valid && in_ready, capture in_a/in_b into the shift registers, capture in_cin, clear the bit counter cnt to 0, and go to SHIFT.
- Beat: in SHIFT, ser_valid=1, ser_a=sh_a[0], ser_b=sh_b[0], ser_first=(cnt==0), ser_last=(cnt==N-1).
- Advance: when ser_valid && ser_ready and not last, shift sh_a/sh_b right by 1 with zero fill, and increment cnt.
- cnt width is $clog2(N). cnt never exceeds N-1; there is no wrap inside a word.
- On the last beat consumed:
  - if in_valid in the same cycle, load the new word and stay in SHIFT with cnt=0;
  - otherwise go to IDLE.
- in_ready = !rst && (state==IDLE || (ser_valid && ser_ready && ser_last)). It is combinational, with no dependence on in_valid.
- Stall: while ser_ready is low, all serial outputs and internal state hold.
- ser_cin is forced 0 when ser_first is low, so the downstream carry flop sees cin only once per word.
- busy = (state==SHIFT).

## Timing
- Reset values: ser_valid, ser_a, ser_b, ser_cin, ser_first, ser_last, busy all 0; in_ready 0 while rst is high, 1 on the first cycle after release.
- Latency: a pair accepted at edge k presents bit 0 in cycle k+1.
- Throughput: with ser_ready tied high, each word takes exactly N cycles and there are no bubbles between words.
- A word accepted with ser_ready permanently high shows ser_last in cycle k+N.
- Reset mid-word: the word is discarded. The FSM goes to IDLE, registers clear, and no partial beats follow.
- In IDLE, ser_valid=0 and all serial data outputs are 0.
- All outputs except in_ready are registered or decoded from registers, with no combinational path from in_*.

## Structure
- Shared package serial_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - a CNT_W function returning $clog2(N);
  - a localparam for the minimum legal N (2).
- Sub-module piso_shift (parameter N): a parallel-load, right-shifting register with load/shift/hold controls.
  - Instantiated twice, for A and B.
  - Asynchronous active-high reset on rst.
- FSM, counter and framing decode live in serial_operand_loader.

## Test plan
- Basic word, N=16, ser_ready=1: a=16'h0005, b=16'h0003, cin=1.
  - ser_a = 1,0,1,0 then zeros.
  - ser_b = 1,1 then zeros.
  - ser_cin=1 only at beat 0.
  - ser_first at beat 0, ser_last at beat 15, ser_valid low at beat 16.
- Back-to-back: in_valid held high with a=16'hFFFF/b=16'h0001 then a=16'h8000/b=16'h8000.
  - in_ready pulses only on the last-beat cycle.
  - The second word's bit 0 follows beat 15 with no gap.
  - 32 contiguous ser_valid cycles.
- Stall: drop ser_ready for 3 cycles at beat 5 of a=16'hA5A5.
  - ser_a, ser_first and ser_last hold the beat-5 values.
  - The word completes in 19 cycles.
  - The bit sequence matches 16'hA5A5 LSB-first.
- Reset mid-word: assert rst at beat 7.
  - All outputs go to 0 asynchronously.
  - After release, in_ready=1 and busy=0.
  - The next word a=16'h0001 starts at bit 0.
- Idle hold-off: in_valid low for 10 cycles after reset.
  - ser_valid stays 0 and in_ready stays 1.
  - When in_valid rises, ser_valid goes high on the next cycle.
- Minimum width, N=2: a=2'b10, b=2'b11, cin=0.
  - Beat 0: ser_a=0, ser_b=1, ser_first=1.
  - Beat 1: ser_a=1, ser_b=1, ser_last=1.

Source files
------------

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Shared declarations for the bit-serial operand loader:
//     - state_e : loader FSM states (IDLE, SHIFT)
//     - MIN_N   : smallest legal operand width
//     - CNT_W() : width of the per-word bit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_pkg;

    // Smallest operand width the loader supports (bit 0 and bit N-1 must differ).
    localparam int MIN_N = 2;

    // Loader FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit-counter width: enough to index bits 0..n-1 of a word.
    function automatic int CNT_W(input int n);
        int w;
        if (n < MIN_N) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// ---------------------------------------------------------------------------
// piso_shift
//   Parallel-in / serial-out register, shifting right (towards bit 0) with
//   zero fill. Load has priority over shift; with neither asserted it holds.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the register
//   load_i  : capture par_i this cycle
//   shift_i : shift right by one this cycle
//   par_i   : parallel load value
//   lsb_o   : current bit 0 of the register (registered)
// ---------------------------------------------------------------------------
module piso_shift #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] par_i,
    output logic         lsb_o
);

    logic [N-1:0] sh_q;
    logic [N-1:0] sh_d;

    // Next-state selection: load, shift right with zero fill, or hold.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = par_i;
        end else if (shift_i) begin
            sh_d = {1'b0, sh_q[N-1:1]};
        end else begin
            sh_d = sh_q;
        end
    end

    // Shift register storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign lsb_o = sh_q[0];

endmodule

// File: rtl/serial_operand_loader.sv
// ---------------------------------------------------------------------------
// serial_operand_loader
//   Accepts a parallel operand pair (A, B, carry-in) through a valid/ready
//   handshake and streams it LSB-first, one bit pair per consumed beat, with
//   first/last framing for the downstream bit-serial adder. A new word can be
//   loaded in the same cycle the last beat of the previous word is consumed,
//   so back-to-back words stream without a bubble.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : parallel operand pair present
//   in_ready   : loader accepts a pair this cycle (combinational)
//   in_a/in_b  : operands, N bits each
//   in_cin     : carry-in for the word
//   ser_valid  : serial beat presented
//   ser_ready  : downstream consumes the beat (low = stall)
//   ser_a/ser_b: current operand bits
//   ser_cin    : carry-in, only on the first beat of a word
//   ser_first  : beat is bit 0
//   ser_last   : beat is bit N-1
//   busy       : a word is loaded and not fully sent
// ---------------------------------------------------------------------------
module serial_operand_loader
    import serial_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_a,
    output logic         ser_b,
    output logic         ser_cin,
    output logic         ser_first,
    output logic         ser_last,
    output logic         busy
);

    localparam int CW = CNT_W(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          cin_q;
    logic          cin_d;

    logic          shifting_s;
    logic          last_s;
    logic          consume_s;
    logic          load_s;
    logic          shift_s;
    logic          a_lsb_s;
    logic          b_lsb_s;

    // Framing and handshake decode, all derived from registered state except
    // the ready term, which must see the consuming beat in the same cycle.
    assign shifting_s = (state_q == SHIFT);
    assign last_s     = shifting_s && (cnt_q == LAST_CNT);
    assign consume_s  = shifting_s && ser_ready;
    assign in_ready   = !rst && ((state_q == IDLE) || (consume_s && last_s));
    assign load_s     = in_valid && in_ready;
    // The last beat never shifts: either a new word overwrites the register
    // or the FSM idles and the data outputs are gated off.
    assign shift_s    = consume_s && !last_s;

    piso_shift #(.N(N)) u_shift_a (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .shift_i (shift_s),
        .par_i   (in_a),
        .lsb_o   (a_lsb_s)
    );

    piso_shift #(.N(N)) u_shift_b (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .shift_i (shift_s),
        .par_i   (in_b),
        .lsb_o   (b_lsb_s)
    );

    // FSM next state, bit counter and captured carry-in.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
        case (state_q)
            IDLE: begin
                if (load_s) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    cin_d   = in_cin;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (consume_s && last_s) begin
                    if (load_s) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        cin_d   = in_cin;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        cin_d   = 1'b0;
                    end
                end else if (consume_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                cin_d   = 1'b0;
            end
        endcase
    end

    // FSM, counter and carry-in registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cin_q   <= cin_d;
        end
    end

    // Serial outputs decoded from registers; data is gated to 0 while idle
    // because the shift registers still hold the final bit of the last word.
    assign ser_valid = shifting_s;
    assign ser_a     = shifting_s && a_lsb_s;
    assign ser_b     = shifting_s && b_lsb_s;
    assign ser_first = shifting_s && (cnt_q == '0);
    assign ser_last  = last_s;
    assign ser_cin   = ser_first && cin_q;
    assign busy      = shifting_s;

endmodule

// File: tb/tb_serial_operand_loader.sv
module tb_serial_operand_loader;

    logic        clk;
    logic        rst;
    // N=16 instance
    logic        in_valid, in_ready, in_cin;
    logic [15:0] in_a, in_b;
    logic        ser_valid, ser_ready, ser_a, ser_b, ser_cin, ser_first, ser_last, busy;
    // N=2 instance
    logic        v2, r2_in, c2, sv2, sr2, sa2, sb2, sc2, sf2, sl2, busy2;
    logic [1:0]  a2, b2;

    logic [5:0]  obs, obs2;
    int          checks;
    int          errors;

    assign obs  = {ser_valid, ser_a, ser_b, ser_cin, ser_first, ser_last};
    assign obs2 = {sv2, sa2, sb2, sc2, sf2, sl2};

    serial_operand_loader #(.N(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_a(ser_a), .ser_b(ser_b),
        .ser_cin(ser_cin), .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
    );

    serial_operand_loader #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2_in),
        .in_a(a2), .in_b(b2), .in_cin(c2),
        .ser_valid(sv2), .ser_ready(sr2), .ser_a(sa2), .ser_b(sb2),
        .ser_cin(sc2), .ser_first(sf2), .ser_last(sl2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference beat: {valid, a bit, b bit, cin, first, last} for bit i of an n-bit word.
    function automatic logic [5:0] exp_beat(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input int i, input int n);
        logic [15:0] sa;
        logic [15:0] sb;
        sa = a >> i;
        sb = b >> i;
        return {1'b1, sa[0], sb[0], (i == 0) ? cin : 1'b0, (i == 0), (i == n - 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_cin = 1'b0; ser_ready = 1'b1;
        v2 = 1'b0; a2 = 2'b00; b2 = 2'b00; c2 = 1'b0; sr2 = 1'b1;
        #1;
        checks++; if (obs !== 6'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_outputs obs=%b busy=%b want 0", obs, busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want 0", in_ready); end
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || obs !== 6'b0) begin
            errors++; $display("FAIL reset_release in_ready=%b busy=%b obs=%b want 1,0,0", in_ready, busy, obs); end
        tick();
    endtask

    task automatic test_idle_holdoff();
        logic [15:0] a, b;
        a = 16'($urandom); b = 16'($urandom);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b0;
            #1;
            checks++; if (ser_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL idle_holdoff c=%0d ser_valid=%b in_ready=%b want 0,1", c, ser_valid, in_ready); end
            tick();
        end
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (obs !== exp_beat(a, b, 1'b1, 0, 16)) begin
            errors++; $display("FAIL idle_first_beat got=%b want %b", obs, exp_beat(a, b, 1'b1, 0, 16)); end
        repeat (16) tick();
        checks++; if (obs !== 6'b0) begin errors++; $display("FAIL idle_drain got=%b want 0", obs); end
    endtask

    task automatic test_basic();
        ser_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'h0005; in_b = 16'h0003; in_cin = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs !== exp_beat(16'h0005, 16'h0003, 1'b1, i, 16)) begin
                errors++; $display("FAIL basic_beat%0d got=%b want %b", i, obs, exp_beat(16'h0005, 16'h0003, 1'b1, i, 16)); end
            tick();
        end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL basic_end ser_valid=%b want 0", ser_valid); end
    endtask

    task automatic test_back_to_back();
        logic c0, c1;
        logic [5:0] e;
        c0 = 1'($urandom); c1 = 1'($urandom);
        ser_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_cin = c0;
        tick();
        in_a = 16'h8000; in_b = 16'h8000; in_cin = c1;
        for (int t = 0; t < 32; t++) begin
            if (t == 16) in_valid = 1'b0;
            #1;
            e = (t < 16) ? exp_beat(16'hFFFF, 16'h0001, c0, t, 16) : exp_beat(16'h8000, 16'h8000, c1, t - 16, 16);
            checks++; if (obs !== e) begin errors++; $display("FAIL b2b_beat t=%0d got=%b want %b", t, obs, e); end
            checks++; if (in_ready !== ((t == 15) || (t == 31))) begin
                errors++; $display("FAIL b2b_in_ready t=%0d got=%b want %b", t, in_ready, (t == 15) || (t == 31)); end
            tick();
        end
        checks++; if (obs !== 6'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end obs=%b busy=%b want 0", obs, busy); end
    endtask

    task automatic test_stall();
        logic [15:0] b, got;
        logic cin;
        int beat;
        b = 16'($urandom); cin = 1'($urandom); got = 16'h0;
        ser_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'hA5A5; in_b = b; in_cin = cin;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 19; c++) begin
            beat = (c < 5) ? c : ((c <= 8) ? 5 : c - 3);
            ser_ready = !(c >= 5 && c <= 7);
            #1;
            checks++; if (obs !== exp_beat(16'hA5A5, b, cin, beat, 16)) begin
                errors++; $display("FAIL stall_beat c=%0d got=%b want %b", c, obs, exp_beat(16'hA5A5, b, cin, beat, 16)); end
            if (ser_ready) got[beat] = ser_a;
            tick();
        end
        ser_ready = 1'b1;
        checks++; if (got !== 16'hA5A5) begin errors++; $display("FAIL stall_bits got=%h want a5a5", got); end
        checks++; if (obs !== 6'b0) begin errors++; $display("FAIL stall_done_19 got=%b want 0", obs); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] a, b;
        logic cin;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        ser_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (obs !== exp_beat(a, b, cin, i, 16)) begin
                errors++; $display("FAIL rstmid_beat%0d got=%b want %b", i, obs, exp_beat(a, b, cin, i, 16)); end
            if (i < 7) tick();
        end
        rst = 1'b1;
        #1;
        checks++; if (obs !== 6'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_async obs=%b busy=%b in_ready=%b want 0", obs, busy, in_ready); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || obs !== 6'b0) begin
            errors++; $display("FAIL rstmid_release in_ready=%b busy=%b obs=%b want 1,0,0", in_ready, busy, obs); end
        in_valid = 1'b1; in_a = 16'h0001; in_b = b; in_cin = cin;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs !== exp_beat(16'h0001, b, cin, i, 16)) begin
                errors++; $display("FAIL rstmid_next_beat%0d got=%b want %b", i, obs, exp_beat(16'h0001, b, cin, i, 16)); end
            tick();
        end
    endtask

    task automatic test_min_width();
        sr2 = 1'b1;
        v2 = 1'b1; a2 = 2'b10; b2 = 2'b11; c2 = 1'b0;
        tick();
        v2 = 1'b0;
        checks++; if (obs2 !== 6'b101010) begin errors++; $display("FAIL n2_beat0 got=%b want 101010", obs2); end
        tick();
        checks++; if (obs2 !== 6'b111001) begin errors++; $display("FAIL n2_beat1 got=%b want 111001", obs2); end
        tick();
        checks++; if (obs2 !== 6'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL n2_end got=%b busy=%b want 0", obs2, busy2); end
    endtask

    task automatic test_random();
        logic [5:0] q[$];
        logic [5:0] e;
        logic exp_ready;
        logic pending;
        int guard;
        pending = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
            end
            ser_ready = ($urandom_range(0, 3) != 0);
            #1;
            e = (q.size() != 0) ? q[0] : 6'b0;
            exp_ready = (q.size() == 0) || (q.size() == 1 && ser_ready);
            checks++; if (obs !== e || busy !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_beat c=%0d got=%b busy=%b want %b", c, obs, busy, e); end
            checks++; if (in_ready !== exp_ready) begin
                errors++; $display("FAIL rand_in_ready c=%0d got=%b want %b", c, in_ready, exp_ready); end
            if (q.size() != 0 && ser_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                for (int i = 0; i < 16; i++) q.push_back(exp_beat(in_a, in_b, in_cin, i, 16));
                pending = 1'b0;
            end else begin
                pending = in_valid;
            end
            tick();
        end
        in_valid = 1'b0; ser_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 40) begin
            #1;
            checks++; if (obs !== q[0]) begin errors++; $display("FAIL rand_drain got=%b want %b", obs, q[0]); end
            void'(q.pop_front());
            guard++;
            tick();
        end
        checks++; if (obs !== 6'b0 || q.size() != 0) begin
            errors++; $display("FAIL rand_final obs=%b left=%0d want 0", obs, q.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle_holdoff();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_min_width();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
